// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver, LSB first, with a first-word-fall-through
// byte FIFO on the read side. A 16x oversample tick is derived from the
// system clock, so everything runs in the single clk domain.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | line idle, waiting for rx_s to fall
// S_START     | qualifying the start bit at its centre (glitch reject)
// S_DATA      | sampling 8 data bits at their centres, LSB first
// S_STOP      | sampling the stop bit; push on 1, frame error on 0
// S_WAIT_IDLE | after a framing error, hold until the line returns high
module uart_rx_fifo #(
  parameter int TICK_DIV   = 326,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [CW-1:0] fifo_count,
  output logic          frame_err,
  output logic          overrun,
  output logic          busy
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int AW = CW - 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic          rx_m;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  state_t        state;
  state_t        state_nxt;
  logic [OW-1:0] os_cnt;
  logic [OW-1:0] os_nxt;
  logic [3:0]    bit_cnt;
  logic [3:0]    bit_nxt;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_nxt;

  logic          push;
  logic          ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_en;

  // Two-flop synchronizer for the asynchronous serial input; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Free-running oversample tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // FSM state register together with its oversample/bit counters and shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      os_cnt    <= os_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // Next-state logic; every transition is gated by the oversample tick.
  always_comb begin
    state_nxt = state;
    os_nxt    = os_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_nxt = S_START;
            os_nxt    = '0;
          end
        end
        S_START: begin
          if (os_cnt == OS_HALF) begin
            os_nxt = '0;
            if (!rx_s) begin
              state_nxt = S_DATA;
              bit_nxt   = '0;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            os_nxt = os_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (os_cnt == OS_LAST) begin
            shift_nxt = {rx_s, shift_reg[7:1]};
            os_nxt    = '0;
            bit_nxt   = bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              state_nxt = S_STOP;
            end
          end else begin
            os_nxt = os_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (os_cnt == OS_LAST) begin
            os_nxt    = '0;
            state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
          end else begin
            os_nxt = os_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: push/frame-error request on the stop-centre tick, busy flag.
  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    busy     = (state != S_IDLE);
    if (tick && (state == S_STOP) && (os_cnt == OS_LAST)) begin
      push     = rx_s;
      ferr_set = !rx_s;
    end
  end

  // FIFO status. A pop in the same cycle frees a slot, so a full FIFO still
  // accepts the push without overrun.
  assign fifo_count = wr_ptr - rd_ptr;
  assign rd_valid   = (fifo_count != '0);
  assign full       = (fifo_count == DEPTH_C);
  assign pop        = rd_valid && rd_ready;
  assign wr_en      = push && (!full || pop);
  assign rd_data    = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage; contents are only observable through rd_valid gating.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= shift_reg;
    end
  end

  // One-cycle error pulses; push and frame error are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with TICK_DIV=4, OVERSAMPLE=16 (64 clk/bit).
module tb_uart_rx_fifo;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_both = 0;
  int f0;
  int o0;
  int j;
  int pop_cyc;

  uart_rx_fifo #(
    .TICK_DIV   (4),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (8),
    .CW         (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count high cycles of each error pulse, and any cycle where both are high.
  always @(negedge clk) begin
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun) n_ovr <= n_ovr + 1;
    if (frame_err && overrun) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 ns after.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Drive the first nbits of a start/data/stop frame. When pop_cyc >= 0,
  // rd_ready is high for exactly the cycle following edge pop_cyc.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int nbits,
                             input int pop_at, input logic [7:0] pop_exp);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      for (int c = 0; c < BIT; c++) begin
        if (pop_at >= 0) begin
          rd_ready = (cyc == pop_at);
          if (cyc == pop_at) chk("pop_head", 32'(rd_data), 32'(pop_exp));
        end
        step(1);
      end
    end
    if (pop_at >= 0) rd_ready = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
  endtask

  initial begin
    rx       = 1'b1;
    rd_ready = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    step(20);

    // 1: single byte 0x48, held then popped
    f0 = n_ferr; o0 = n_ovr;
    drive_frame(8'h48, 1'b1, 10, -1, 8'h00);
    step(4);
    chk("t1_valid", 32'(rd_valid), 32'd1);
    chk("t1_data", 32'(rd_data), 32'h48);
    chk("t1_count", 32'(fifo_count), 32'd1);
    step(5);
    chk("t1_hold", 32'(rd_data), 32'h48);
    chk("t1_ferr", 32'(n_ferr - f0), 32'd0);
    chk("t1_ovr", 32'(n_ovr - o0), 32'd0);
    pop_one();
    chk("t1_valid_pop", 32'(rd_valid), 32'd0);
    chk("t1_count_pop", 32'(fifo_count), 32'd0);
    step(20);

    // 2: 12-clk low glitch is rejected
    rx = 1'b0;
    step(12);
    chk("t2_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    step(40);
    chk("t2_busy_lo", 32'(busy), 32'd0);
    chk("t2_count", 32'(fifo_count), 32'd0);
    chk("t2_ferr", 32'(n_ferr - f0), 32'd0);
    step(20);

    // 3: framing error on 0x55 with a long low, then 0x3C received
    drive_frame(8'h55, 1'b0, 10, -1, 8'h00);
    step(60);
    chk("t3_busy_hold", 32'(busy), 32'd1);
    chk("t3_ferr", 32'(n_ferr - f0), 32'd1);
    chk("t3_count", 32'(fifo_count), 32'd0);
    rx = 1'b1;
    step(16);
    chk("t3_busy_lo", 32'(busy), 32'd0);
    step(20);
    drive_frame(8'h3C, 1'b1, 10, -1, 8'h00);
    step(4);
    chk("t3_data", 32'(rd_data), 32'h3C);
    chk("t3_count2", 32'(fifo_count), 32'd1);
    chk("t3_ferr2", 32'(n_ferr - f0), 32'd1);
    pop_one();
    step(20);

    // 4: nine back-to-back bytes, ninth overruns
    o0 = n_ovr;
    for (int b = 1; b <= 8; b++) drive_frame(8'(b), 1'b1, 10, -1, 8'h00);
    chk("t4_count8", 32'(fifo_count), 32'd8);
    chk("t4_ovr0", 32'(n_ovr - o0), 32'd0);
    drive_frame(8'h09, 1'b1, 10, -1, 8'h00);
    step(4);
    chk("t4_ovr1", 32'(n_ovr - o0), 32'd1);
    chk("t4_count_full", 32'(fifo_count), 32'd8);
    for (int b = 1; b <= 8; b++) begin
      chk("t4_drain", 32'(rd_data), 32'(b));
      pop_one();
    end
    chk("t4_empty", 32'(rd_valid), 32'd0);
    step(20);

    // 5: full FIFO, pop exactly in the push cycle of 0x0A
    o0 = n_ovr;
    for (int b = 2; b <= 9; b++) drive_frame(8'(b), 1'b1, 10, -1, 8'h00);
    chk("t5_count8", 32'(fifo_count), 32'd8);
    j = cyc;
    pop_cyc = ((j + 6) / 4) * 4 + 607;
    drive_frame(8'h0A, 1'b1, 10, pop_cyc, 8'h02);
    step(4);
    chk("t5_ovr", 32'(n_ovr - o0), 32'd0);
    chk("t5_count", 32'(fifo_count), 32'd8);
    for (int b = 3; b <= 10; b++) begin
      chk("t5_drain", 32'(rd_data), 32'(b));
      pop_one();
    end
    chk("t5_empty", 32'(rd_valid), 32'd0);
    step(20);

    // 6: async reset mid-DATA with 2 bytes queued
    drive_frame(8'h11, 1'b1, 10, -1, 8'h00);
    drive_frame(8'h22, 1'b1, 10, -1, 8'h00);
    step(4);
    chk("t6_count2", 32'(fifo_count), 32'd2);
    drive_frame(8'hA5, 1'b1, 4, -1, 8'h00);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_data", 32'(rd_data), 32'd0);
    rx = 1'b1;
    step(3);
    rst_n = 1'b1;
    cyc   = 0;
    step(10);
    drive_frame(8'hA5, 1'b1, 10, -1, 8'h00);
    step(4);
    chk("t6_data", 32'(rd_data), 32'hA5);
    chk("t6_count", 32'(fifo_count), 32'd1);
    chk("t6_valid", 32'(rd_valid), 32'd1);
    chk("both_pulses", 32'(n_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
